// File: rtl/conv2d3x3_mc_stream_if.sv
// Stream, weight-write and error signals of conv2d3x3_mc_stream.
// slave: the convolution block; master: the producer/consumer driving it.
interface conv2d3x3_mc_stream_if #(
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 16
);
    localparam int AW = $clog2(9 * CHANNELS + 1);

    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;
    logic                           w_wr_en;
    logic [AW-1:0]                  w_addr;
    logic [DATA_WIDTH-1:0]          w_data;
    logic                           w_err;

    modport slave (
        input  in_data, in_valid, out_ready, w_wr_en, w_addr, w_data,
        output in_ready, out_data, out_valid, out_last, w_err
    );

    modport master (
        output in_data, in_valid, out_ready, w_wr_en, w_addr, w_data,
        input  in_ready, out_data, out_valid, out_last, w_err
    );
endinterface

// File: rtl/conv2d3x3_mc_stream.sv
// Streaming 3x3 valid convolution over CHANNELS packed channels with bias, rounding and saturation.
// Optional feature macro LEAKY_RELU_EN: negative results are divided by 8 in the requantise stage.
module conv2d3x3_mc_stream #(
    parameter int IMG_SIZE   = 416,
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    conv2d3x3_mc_stream_if.slave   bus
);
    localparam int DW   = DATA_WIDTH;
    localparam int NT   = 9 * CHANNELS;
    localparam int AW   = $clog2(NT + 1);
    localparam int CW   = $clog2(IMG_SIZE);
    localparam int PW   = 2 * DW;
    localparam int ACCW = 2 * DW + $clog2(NT) + 1;
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [ACCW-1:0] RND     = ACCW'(64'sd1 <<< (FRAC_BITS - 1));

    logic signed [DW-1:0]   r_weight [NT];
    logic signed [DW-1:0]   r_bias;
    logic signed [DW-1:0]   r_lb0    [CHANNELS][IMG_SIZE];
    logic signed [DW-1:0]   r_lb1    [CHANNELS][IMG_SIZE];
    logic signed [DW-1:0]   r_win    [CHANNELS][9];
    logic [CW-1:0]          r_col, r_row;
    logic                   r_rdy, r_werr;
    logic                   r_v1, r_v2, r_v3, r_vo;
    logic                   r_l1, r_l2, r_l3, r_lo;
    logic signed [PW-1:0]   r_prod   [NT];
    logic signed [ACCW-1:0] r_acc;
    logic signed [DW-1:0]   r_out;

    logic signed [DW-1:0]   w_px     [CHANNELS];
    logic signed [PW-1:0]   w_prod   [NT];
    logic signed [ACCW-1:0] w_sum, w_rnd, w_shr;
    logic signed [DW-1:0]   w_sat, w_act;
    logic w_stall, w_accept, w_col_end, w_row_end, w_busy, w_wr_ok;

    assign w_stall   = r_vo & ~bus.out_ready;
    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_col_end = (r_col == CW'(IMG_SIZE - 1));
    assign w_row_end = (r_row == CW'(IMG_SIZE - 1));
    assign w_busy    = (r_col != '0) | (r_row != '0) | r_v1 | r_v2 | r_v3 | r_vo;
    assign w_wr_ok   = bus.w_wr_en & ~w_busy & ~bus.in_valid & (bus.w_addr <= AW'(NT));

    assign bus.in_ready  = r_rdy & ~w_stall;
    assign bus.out_data  = r_out;
    assign bus.out_valid = r_vo;
    assign bus.out_last  = r_lo;
    assign bus.w_err     = r_werr;

    // Unpack the channel pixels of the current beat.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_px[c] = bus.in_data[c*DW +: DW];
        end
    end

    // Ready enable, write error pulse, weight/bias storage.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rdy  <= 1'b0;
            r_werr <= 1'b0;
            r_bias <= '0;
            for (int i = 0; i < NT; i++) r_weight[i] <= '0;
        end else begin
            r_rdy  <= 1'b1;
            r_werr <= bus.w_wr_en & ~w_wr_ok;
            if (w_wr_ok && bus.w_addr == AW'(NT)) r_bias <= bus.w_data;
            for (int i = 0; i < NT; i++) begin
                if (w_wr_ok && bus.w_addr == AW'(i)) r_weight[i] <= bus.w_data;
            end
        end
    end

    // Raster counters, line buffers and window shift; all advance only on an accepted beat.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_col <= '0;
            r_row <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int x = 0; x < IMG_SIZE; x++) begin
                    r_lb0[c][x] <= '0;
                    r_lb1[c][x] <= '0;
                end
                for (int t = 0; t < 9; t++) r_win[c][t] <= '0;
            end
        end else if (w_accept) begin
            r_col <= w_col_end ? '0 : r_col + CW'(1);
            if (w_col_end) r_row <= w_row_end ? '0 : r_row + CW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                r_lb0[c][r_col] <= r_lb1[c][r_col];
                r_lb1[c][r_col] <= w_px[c];
                for (int ky = 0; ky < 3; ky++) begin
                    r_win[c][3*ky]     <= r_win[c][3*ky + 1];
                    r_win[c][3*ky + 1] <= r_win[c][3*ky + 2];
                end
                // Newest column: oldest row on top (ky=0), current beat at the bottom.
                r_win[c][2] <= r_lb0[c][r_col];
                r_win[c][5] <= r_lb1[c][r_col];
                r_win[c][8] <= w_px[c];
            end
        end
    end

    // Per-tap products of the window.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int t = 0; t < 9; t++) begin
                w_prod[c*9 + t] = r_win[c][t] * r_weight[c*9 + t];
            end
        end
    end

    // Cross-channel sum with the bias aligned to the product fraction.
    always_comb begin
        w_sum = ACCW'(r_bias) <<< FRAC_BITS;
        for (int i = 0; i < NT; i++) begin
            w_sum = w_sum + ACCW'(r_prod[i]);
        end
    end

    // Round half up, rescale, saturate and apply the optional activation.
    always_comb begin
        w_rnd = r_acc + RND;
        w_shr = w_rnd >>> FRAC_BITS;
        if (w_shr > SAT_MAX) begin
            w_sat = SAT_MAX[DW-1:0];
        end else if (w_shr < SAT_MIN) begin
            w_sat = SAT_MIN[DW-1:0];
        end else begin
            w_sat = w_shr[DW-1:0];
        end
`ifdef LEAKY_RELU_EN
        if (w_sat[DW-1]) begin
            w_act = w_sat >>> 3;
        end else begin
            w_act = w_sat;
        end
`else
        w_act = w_sat;
`endif
    end

    // Four-stage result pipeline; every stage freezes while the output is stalled.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            {r_v1, r_v2, r_v3, r_vo} <= 4'b0000;
            {r_l1, r_l2, r_l3, r_lo} <= 4'b0000;
            for (int i = 0; i < NT; i++) r_prod[i] <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else if (!w_stall) begin
            r_v1 <= w_accept & (r_row >= CW'(2)) & (r_col >= CW'(2));
            r_l1 <= w_accept & w_row_end & w_col_end;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            for (int i = 0; i < NT; i++) r_prod[i] <= w_prod[i];
            r_v3  <= r_v2;
            r_l3  <= r_l2;
            r_acc <= w_sum;
            r_vo  <= r_v3;
            r_lo  <= r_l3;
            r_out <= w_act;
        end
    end
endmodule

// File: tb/tb_conv2d3x3_mc_stream.sv
// Randomised self-checking bench for conv2d3x3_mc_stream (4x4 frame, 2 channels, Q8.8).
module tb_conv2d3x3_mc_stream;
    localparam int N = 4;
    localparam int CH = 2;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    conv2d3x3_mc_stream_if #(.CHANNELS(CH), .DATA_WIDTH(16)) bus();

    conv2d3x3_mc_stream #(.IMG_SIZE(N), .CHANNELS(CH), .DATA_WIDTH(16), .FRAC_BITS(8)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic signed [15:0] g_px [CH][N][N];
    logic signed [15:0] g_w  [CH][9];
    logic signed [15:0] g_b;
    logic [15:0] exp_d[$], obs_d[$];
    bit          exp_l[$], obs_l[$];
    int werr_cnt, stall_cnt, stall_viol, lat;

    function automatic void set_const(input logic [15:0] px, input logic [15:0] w, input logic [15:0] b);
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < N; r++) for (int x = 0; x < N; x++) g_px[c][r][x] = px;
            for (int t = 0; t < 9; t++) g_w[c][t] = w;
        end
        g_b = b;
    endfunction

    // Reference: direct valid convolution of the whole frame.
    function automatic void compute_expected();
        longint s;
        exp_d.delete(); exp_l.delete();
        for (int r = 2; r < N; r++) begin
            for (int x = 2; x < N; x++) begin
                s = longint'(g_b) * 256;
                for (int c = 0; c < CH; c++)
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            s += longint'(g_px[c][r-2+ky][x-2+kx]) * longint'(g_w[c][3*ky+kx]);
                s = (s + 128) >>> 8;
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
`ifdef LEAKY_RELU_EN
                if (s < 0) s = s >>> 3;
`endif
                exp_d.push_back(16'(s));
                exp_l.push_back(r == N-1 && x == N-1);
            end
        end
    endfunction

    task automatic write_w(input int addr, input logic [15:0] data, output bit err);
        @(negedge Clk);
        bus.w_wr_en = 1'b1; bus.w_addr = 5'(addr); bus.w_data = data;
        @(posedge Clk);
        #1 err = bus.w_err;
        @(negedge Clk);
        bus.w_wr_en = 1'b0;
    endtask

    task automatic load_all();
        bit e;
        int ecnt = 0;
        for (int c = 0; c < CH; c++)
            for (int t = 0; t < 9; t++) begin
                write_w(c*9 + t, g_w[c][t], e);
                if (e) ecnt++;
            end
        write_w(9*CH, g_b, e);
        if (e) ecnt++;
        checks++;
        if (ecnt != 0) begin errors++; $display("FAIL load_err: got %0d rejected writes, expected 0", ecnt); end
    endtask

    // Drive npix beats; rmode 0: ready high, 1: 1-0-0-1 pattern, 2: random. Optional write at beat wr_at.
    task automatic drive_frame(input int npix, input int rmode, input int wr_at, input int n_exp, input int drain);
        int i = 0, cyc = 0, acc22 = -1, first_v = -1;
        bit wr_done = 1'b0;
        obs_d.delete(); obs_l.delete();
        werr_cnt = 0; stall_cnt = 0; stall_viol = 0;
        while ((i < npix || obs_d.size() < n_exp) && cyc < 400) begin
            @(negedge Clk);
            case (rmode)
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            bus.in_valid = (i < npix);
            if (i < npix)
                for (int c = 0; c < CH; c++) bus.in_data[c*16 +: 16] = g_px[c][i / N][i % N];
            if (i == wr_at && !wr_done) begin
                bus.w_wr_en = 1'b1; bus.w_addr = 5'd0; bus.w_data = 16'h1234; wr_done = 1'b1;
            end else begin
                bus.w_wr_en = 1'b0;
            end
            #1;
            if (bus.w_err) werr_cnt++;
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (bus.out_valid && !bus.out_ready) begin
                stall_cnt++;
                if (bus.in_ready) stall_viol++;
            end
            if (bus.out_valid && bus.out_ready) begin obs_d.push_back(bus.out_data); obs_l.push_back(bus.out_last); end
            if (bus.in_valid && bus.in_ready) begin
                if (i == 2*N + 2) acc22 = cyc;
                i++;
            end
            cyc++;
        end
        checks++;
        if (cyc >= 400) begin errors++; $display("FAIL frame_timeout: got %0d outputs, expected %0d", obs_d.size(), n_exp); end
        for (int d = 0; d <= drain; d++) begin
            @(negedge Clk);
            bus.in_valid = 1'b0; bus.w_wr_en = 1'b0; bus.out_ready = 1'b1;
            #1;
            if (bus.w_err) werr_cnt++;
            if (d < drain && bus.out_valid) begin obs_d.push_back(bus.out_data); obs_l.push_back(bus.out_last); end
        end
        lat = first_v - acc22;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus.w_wr_en = 1'b0; bus.w_addr = '0; bus.w_data = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.w_err, bus.out_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b e=%b d=%h, expected all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.w_err, bus.out_data);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b expected 0", bus.in_ready); end
        @(negedge Clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_ones();
        set_const(16'h0100, 16'h0100, 16'h0000);
        load_all();
        compute_expected();
        drive_frame(N*N, 0, -1, exp_d.size(), 8);
        checks++;
        if (obs_d.size() != 4) begin errors++; $display("FAIL ones_count: got %0d expected 4", obs_d.size()); end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== 16'h1200 || obs_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL ones_out[%0d]: got %h last=%b expected 1200 last=%b", k, obs_d[k], obs_l[k], exp_l[k]);
            end
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL ones_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_saturation();
        for (int neg = 0; neg < 2; neg++) begin
            set_const(16'h7FFF, neg ? 16'h8001 : 16'h7FFF, 16'h7FFF);
            load_all();
            compute_expected();
            drive_frame(N*N, 0, -1, exp_d.size(), 8);
            checks++;
            if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL sat_count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
            for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
                checks++;
                if (obs_d[k] !== (neg ? 16'h8000 : 16'h7FFF)) begin
                    errors++; $display("FAIL sat_out[%0d]: got %h expected %h", k, obs_d[k], neg ? 16'h8000 : 16'h7FFF);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        set_const(16'h0100, 16'h0100, 16'h0000);
        load_all();
        compute_expected();
        drive_frame(N*N, 1, -1, exp_d.size(), 8);
        checks++;
        if (stall_cnt == 0 || stall_viol != 0) begin
            errors++; $display("FAIL bp_ready: got %0d ready-during-stall of %0d stalls, expected 0 of >0", stall_viol, stall_cnt);
        end
        checks++;
        if (obs_d.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", obs_d.size()); end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL bp_out[%0d]: got %h/%b expected %h/%b", k, obs_d[k], obs_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_write_reject();
        bit e;
        set_const(16'h0100, 16'h0100, 16'h0000);
        load_all();
        compute_expected();
        drive_frame(N*N, 0, N + 1, exp_d.size(), 8);
        checks++;
        if (werr_cnt != 1) begin errors++; $display("FAIL wr_busy_err: got %0d pulses expected 1", werr_cnt); end
        write_w(19, 16'hABCD, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL wr_addr_err: got %b expected 1", e); end
        write_w(18, 16'h0000, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL wr_legal_err: got %b expected 0", e); end
        drive_frame(N*N, 0, -1, exp_d.size(), 8);
        checks++;
        if (obs_d.size() != 4) begin errors++; $display("FAIL wr_count: got %0d expected 4", obs_d.size()); end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== 16'h1200 || obs_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL wr_out[%0d]: got %h/%b expected 1200/%b", k, obs_d[k], obs_l[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_midreset();
        set_const(16'h0100, 16'h0100, 16'h0000);
        load_all();
        drive_frame(7, 0, -1, 0, 0);
        @(negedge Clk); Rst = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        for (int reload = 0; reload < 2; reload++) begin
            set_const(16'h0100, reload ? 16'h0100 : 16'h0000, 16'h0000);
            if (reload) load_all();
            compute_expected();
            set_const(16'h0100, 16'h0100, 16'h0000);
            drive_frame(N*N, 0, -1, exp_d.size(), 8);
            checks++;
            if (obs_d.size() != 4) begin errors++; $display("FAIL mrst_count%0d: got %0d expected 4", reload, obs_d.size()); end
            for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
                checks++;
                if (obs_d[k] !== (reload ? 16'h1200 : 16'h0000) || obs_l[k] !== exp_l[k]) begin
                    errors++; $display("FAIL mrst_out%0d[%0d]: got %h/%b expected %h/%b", reload, k, obs_d[k], obs_l[k], exp_d[k], exp_l[k]);
                end
            end
        end
    endtask

    task automatic test_negative();
        logic [15:0] want;
`ifdef LEAKY_RELU_EN
        want = 16'hFF00;
`else
        want = 16'hF800;
`endif
        set_const(16'h0100, 16'hFF00, 16'h0A00);
        load_all();
        drive_frame(N*N, 0, -1, 4, 8);
        checks++;
        if (obs_d.size() != 4) begin errors++; $display("FAIL neg_count: got %0d expected 4", obs_d.size()); end
        for (int k = 0; k < obs_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== want) begin errors++; $display("FAIL neg_out[%0d]: got %h expected %h", k, obs_d[k], want); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < CH; c++) begin
                for (int r = 0; r < N; r++)
                    for (int x = 0; x < N; x++)
                        g_px[c][r][x] = (f == 3) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'sd1024;
                for (int t = 0; t < 9; t++) g_w[c][t] = 16'($urandom_range(0, 1023)) - 16'sd512;
            end
            g_b = 16'($urandom_range(0, 8191)) - 16'sd4096;
            load_all();
            compute_expected();
            drive_frame(N*N, 2, -1, exp_d.size(), 8);
            checks++;
            if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", f, obs_d.size(), exp_d.size()); end
            for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
                checks++;
                if (obs_d[k] !== exp_d[k] || obs_l[k] !== exp_l[k]) begin
                    errors++; $display("FAIL rand%0d_out[%0d]: got %h/%b expected %h/%b", f, k, obs_d[k], obs_l[k], exp_d[k], exp_l[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_saturation();
        test_backpressure();
        test_write_reject();
        test_midreset();
        test_negative();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
